// File: rtl/rfsoc_config.sv
// Shared RFSoC configuration constants: GPIO line map, bus width defaults,
// serial config field widths and field identifiers.
package rfsoc_config;

    localparam int GPIO_W_DEF = 16;
    localparam int CFG_W_DEF  = 32;

    localparam int LINE_SDATA       = 0;
    localparam int LINE_MASK        = 1;
    localparam int LINE_CH_SEL      = 2;
    localparam int LINE_CYCLE_COUNT = 3;
    localparam int LINE_MUX_SET     = 4;
    localparam int LINE_PL_RST      = 5;
    localparam int LINE_TRIGGER     = 6;
    localparam int LINE_ADC_SHIFT   = 7;
    localparam int LINE_ADC_NUM     = 8;
    localparam int LINE_PRE_DELAY   = 9;
    localparam int LINE_POST_DELAY  = 10;
    localparam int LINE_LOCK_WAVE   = 11;
    localparam int LINE_MASK_EN     = 12;
    localparam int LINE_FLUSH       = 13;
    localparam int LINE_USE_DUMMY   = 14;
    localparam int LINE_READOUT_EN  = 15;

    // Lines consumed by the decoder; mask and locking waveform (1, 11) are loaded elsewhere.
    localparam logic [15:0] USED_LINE_MASK = 16'hF7FD;

    localparam int FW_CH_SEL_DEF = 16;
    localparam int FW_COUNT_DEF  = CFG_W_DEF;
    localparam int FW_MUX_SET    = 1;
    localparam int FW_ADC_SHIFT  = 5;
    localparam int FW_MASK_EN    = 1;

    localparam int NUM_FIELDS = 8;

    typedef enum logic [2:0] {
        FID_CH_SEL      = 3'd0,
        FID_CYCLE_COUNT = 3'd1,
        FID_MUX_SET     = 3'd2,
        FID_ADC_SHIFT   = 3'd3,
        FID_ADC_NUM     = 3'd4,
        FID_PRE_DELAY   = 3'd5,
        FID_POST_DELAY  = 3'd6,
        FID_MASK_EN     = 3'd7
    } field_id_e;

endpackage

// File: rtl/gpio_serial_field.sv
// One serially loaded config field: serial-clock edge detect, MSB-first shadow,
// bit counter and commit. GPIO_CFG_GLITCH_FILTER_EN adds a 2-cycle level qualifier.
module gpio_serial_field #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         line_i,
    input  logic         sdata_i,
    input  logic         hold_i,
    output logic [W-1:0] value_o,
    output logic         update_o,
    output logic         busy_o
);
    localparam int CNT_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(W);

    logic [W-1:0]     shadow_q, shadow_d;
    logic [W-1:0]     value_q, value_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             update_q, update_d;
    logic             prev_q;
    logic             edge_det;

`ifdef GPIO_CFG_GLITCH_FILTER_EN
    logic filt_q;

    // An edge counts only once the new level has been seen on two consecutive cycles.
    assign edge_det = line_i & prev_q & ~filt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= 1'b0;
        end else if (line_i == prev_q) begin
            filt_q <= line_i;
        end
    end
`else
    assign edge_det = line_i & ~prev_q;
`endif

    always_comb begin
        shadow_d = shadow_q;
        count_d  = count_q;
        value_d  = value_q;
        update_d = 1'b0;
        if (hold_i) begin
            shadow_d = '0;
            count_d  = '0;
        end else begin
            // A full shadow commits one cycle after its last bit arrives.
            if (count_q == FULL) begin
                value_d  = shadow_q;
                update_d = 1'b1;
                count_d  = '0;
            end
            if (edge_det) begin
                shadow_d = (shadow_q << 1) | W'(sdata_i);
                count_d  = (count_q == FULL) ? CNT_W'(1) : count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            count_q  <= '0;
            value_q  <= '0;
            update_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            count_q  <= count_d;
            value_q  <= value_d;
            update_q <= update_d;
            prev_q   <= line_i;
        end
    end

    assign value_o  = value_q;
    assign update_o = update_q;
    assign busy_o   = (count_q != '0);

endmodule

// File: rtl/gpio_cfg_decoder.sv
// Decodes the PS GPIO bus into serially loaded PL config fields, level lines and a trigger.
// Optional GPIO_CFG_GLITCH_FILTER_EN qualifies serial-clock and trigger edges over 2 cycles.
module gpio_cfg_decoder
    import rfsoc_config::*;
#(
    parameter int GPIO_W = GPIO_W_DEF,
    parameter int CFG_W  = CFG_W_DEF,
    parameter int NUM_CH = FW_CH_SEL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [NUM_CH-1:0] channel_sel,
    output logic [CFG_W-1:0]  cycle_count,
    output logic [CFG_W-1:0]  adc_num_cycles,
    output logic [CFG_W-1:0]  pre_delay,
    output logic [CFG_W-1:0]  post_delay,
    output logic [4:0]        adc_shift_val,
    output logic              mux_set,
    output logic              mask_en,
    output logic              pl_rst_out,
    output logic              flush,
    output logic              use_dummy,
    output logic              readout_en,
    output logic              trigger_pulse,
    output logic              cfg_update,
    output logic              cfg_err
);
    localparam logic [GPIO_W-1:0] USED_MASK = GPIO_W'(USED_LINE_MASK);

    logic [GPIO_W-1:0]     sync1_q, sync2_q;
    logic [NUM_FIELDS-1:0] upd, busy;
    logic                  pl_rst, sdata_bit;
    logic                  trig_prev_q, trig_edge;
    logic                  trigger_q, trigger_d;
    logic                  err_q, err_d;
    logic                  unused_lines;

    assign pl_rst = sync2_q[LINE_PL_RST];

`ifdef GPIO_CFG_GLITCH_FILTER_EN
    logic sdata_dly_q, trig_filt_q;

    // Field clocks are accepted one cycle later, so sdata is delayed to stay aligned.
    assign sdata_bit = sdata_dly_q;
    assign trig_edge = sync2_q[LINE_TRIGGER] & trig_prev_q & ~trig_filt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sdata_dly_q <= 1'b0;
            trig_filt_q <= 1'b0;
        end else begin
            sdata_dly_q <= sync2_q[LINE_SDATA];
            if (sync2_q[LINE_TRIGGER] == trig_prev_q) begin
                trig_filt_q <= sync2_q[LINE_TRIGGER];
            end
        end
    end
`else
    assign sdata_bit = sync2_q[LINE_SDATA];
    assign trig_edge = sync2_q[LINE_TRIGGER] & ~trig_prev_q;
`endif

    // A trigger arriving with any field half-loaded still fires but is flagged.
    assign trigger_d = trig_edge & ~pl_rst;
    assign err_d     = err_q | (trigger_d & (|busy));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            trig_prev_q <= 1'b0;
            trigger_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync1_q     <= gpio_in;
            sync2_q     <= sync1_q;
            trig_prev_q <= sync2_q[LINE_TRIGGER];
            trigger_q   <= trigger_d;
            err_q       <= err_d;
        end
    end

    gpio_serial_field #(.W(NUM_CH)) u_ch_sel (
        .clk(clk), .rst(rst), .line_i(sync2_q[LINE_CH_SEL]), .sdata_i(sdata_bit), .hold_i(pl_rst),
        .value_o(channel_sel), .update_o(upd[FID_CH_SEL]), .busy_o(busy[FID_CH_SEL])
    );

    gpio_serial_field #(.W(CFG_W)) u_cycle_count (
        .clk(clk), .rst(rst), .line_i(sync2_q[LINE_CYCLE_COUNT]), .sdata_i(sdata_bit), .hold_i(pl_rst),
        .value_o(cycle_count), .update_o(upd[FID_CYCLE_COUNT]), .busy_o(busy[FID_CYCLE_COUNT])
    );

    gpio_serial_field #(.W(FW_MUX_SET)) u_mux_set (
        .clk(clk), .rst(rst), .line_i(sync2_q[LINE_MUX_SET]), .sdata_i(sdata_bit), .hold_i(pl_rst),
        .value_o(mux_set), .update_o(upd[FID_MUX_SET]), .busy_o(busy[FID_MUX_SET])
    );

    gpio_serial_field #(.W(FW_ADC_SHIFT)) u_adc_shift (
        .clk(clk), .rst(rst), .line_i(sync2_q[LINE_ADC_SHIFT]), .sdata_i(sdata_bit), .hold_i(pl_rst),
        .value_o(adc_shift_val), .update_o(upd[FID_ADC_SHIFT]), .busy_o(busy[FID_ADC_SHIFT])
    );

    gpio_serial_field #(.W(CFG_W)) u_adc_num (
        .clk(clk), .rst(rst), .line_i(sync2_q[LINE_ADC_NUM]), .sdata_i(sdata_bit), .hold_i(pl_rst),
        .value_o(adc_num_cycles), .update_o(upd[FID_ADC_NUM]), .busy_o(busy[FID_ADC_NUM])
    );

    gpio_serial_field #(.W(CFG_W)) u_pre_delay (
        .clk(clk), .rst(rst), .line_i(sync2_q[LINE_PRE_DELAY]), .sdata_i(sdata_bit), .hold_i(pl_rst),
        .value_o(pre_delay), .update_o(upd[FID_PRE_DELAY]), .busy_o(busy[FID_PRE_DELAY])
    );

    gpio_serial_field #(.W(CFG_W)) u_post_delay (
        .clk(clk), .rst(rst), .line_i(sync2_q[LINE_POST_DELAY]), .sdata_i(sdata_bit), .hold_i(pl_rst),
        .value_o(post_delay), .update_o(upd[FID_POST_DELAY]), .busy_o(busy[FID_POST_DELAY])
    );

    gpio_serial_field #(.W(FW_MASK_EN)) u_mask_en (
        .clk(clk), .rst(rst), .line_i(sync2_q[LINE_MASK_EN]), .sdata_i(sdata_bit), .hold_i(pl_rst),
        .value_o(mask_en), .update_o(upd[FID_MASK_EN]), .busy_o(busy[FID_MASK_EN])
    );

    // Several fields committing together still give a single pulse.
    assign cfg_update    = |upd;
    assign cfg_err       = err_q;
    assign trigger_pulse = trigger_q;
    assign pl_rst_out    = pl_rst;
    assign flush         = sync2_q[LINE_FLUSH];
    assign use_dummy     = sync2_q[LINE_USE_DUMMY];
    assign readout_en    = sync2_q[LINE_READOUT_EN];
    assign unused_lines  = ^(sync2_q & ~USED_MASK);

endmodule
